// File: rtl/exec_sequencer.sv
// Multi-cycle control sequencer for the core datapath: fetch over a req/rdy handshake,
// then decode, execute and write back one instruction at a time; halts on ebreak, illegal or fetch timeout.
module exec_sequencer #(
  parameter int          TIMEOUT = 16,
  parameter int          CNT_W   = 32,
  parameter logic [31:0] EBREAK  = 32'h00100073
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  output logic             imem_req,
  input  logic             imem_rdy,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      inst_q,
  input  logic             dec_wen,
  input  logic             dec_illegal,
  output logic             rf_wen,
  output logic             pc_en,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int                TCNT_W    = $clog2(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t             state_reg, state_next;
  logic [31:0]        inst_reg, inst_next;
  logic [TCNT_W-1:0]  tcnt_reg, tcnt_next;
  logic [1:0]         err_reg, err_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      inst_reg  <= '0;
      tcnt_reg  <= '0;
      err_reg   <= ERR_NONE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      inst_reg  <= inst_next;
      tcnt_reg  <= tcnt_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    inst_next  = inst_reg;
    tcnt_next  = tcnt_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        // A response arriving on the last allowed cycle still wins over the timeout.
        if (imem_rdy) begin
          inst_next  = imem_rdata;
          tcnt_next  = '0;
          state_next = S_DECODE;
        end else if (tcnt_reg == TCNT_LAST) begin
          tcnt_next  = '0;
          err_next   = ERR_TIMEOUT;
          state_next = S_HALT;
        end else begin
          tcnt_next = tcnt_reg + TCNT_W'(1);
        end
      end
      S_DECODE: begin
        if (inst_reg == EBREAK) begin
          err_next   = ERR_NONE;
          state_next = S_HALT;
        end else if (dec_illegal) begin
          err_next   = ERR_ILLEGAL;
          state_next = S_HALT;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        state_next = S_WB;
      end
      S_WB: begin
        cnt_next   = cnt_reg + CNT_W'(1);
        state_next = stop ? S_IDLE : S_FETCH;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Moore outputs; rf_wen additionally suppresses writes to x0.
  assign imem_req    = (state_reg == S_FETCH);
  assign pc_en       = (state_reg == S_WB);
  assign rf_wen      = (state_reg == S_WB) && dec_wen && (inst_reg[11:7] != 5'd0);
  assign busy        = (state_reg != S_IDLE) && (state_reg != S_HALT);
  assign halted      = (state_reg == S_HALT);
  assign inst_q      = inst_reg;
  assign err_code    = err_reg;
  assign retired_cnt = cnt_reg;

endmodule
